mod_mul_seq: RTL and testbench



---
 rtl/ntt_pkg.sv | 14 +
 rtl/mod_csub.sv | 21 ++
 rtl/mod_mul_seq.sv | 126 ++++++++++++
 tb/tb_mod_mul_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath blocks.
// Default width, default modulus and multiplier FSM states.
package ntt_pkg;

   localparam int WIDTH_DEFAULT = 12;
   localparam int Q_DEFAULT     = 3329;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mod_csub.sv
// Conditional modular subtract: y = (x >= q) ? x - q : x.
// Valid when x < 2q, so one subtract brings the value below q.
module mod_csub
   import ntt_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [WIDTH:0]   x_i,
   input  logic [WIDTH-1:0] q_i,
   output logic [WIDTH:0]   y_o
);

   logic [WIDTH:0] q_ext;

   // Zero-extend q and subtract it once if x has reached it
   always_comb begin
      q_ext = {1'b0, q_i};
      y_o   = (x_i >= q_ext) ? (x_i - q_ext) : x_i;
   end

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier, MSB-first interleaved
// shift-and-add with conditional subtraction per step.
module mod_mul_seq
   import ntt_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock_i,
   input  logic             nreset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] q_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             err_o
);

   localparam int CW = $clog2(WIDTH);

   mul_state_e     state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   logic             pre_err;
   logic [WIDTH:0]   dbl_raw, dbl_red;
   logic [WIDTH:0]   add_raw, add_red;
   logic [WIDTH-1:0] add_term;

   // Operand precondition and one shift-and-add step on acc
   always_comb begin
      pre_err  = (a_i >= q_i) || (b_i >= q_i)
               || (q_i < WIDTH'(2));
      dbl_raw  = {acc_q, 1'b0};
      add_term = b_q[cnt_q] ? a_q : '0;
      add_raw  = dbl_red + {1'b0, add_term};
   end

   mod_csub #(.WIDTH(WIDTH)) u_csub_dbl (
      .x_i (dbl_raw),
      .q_i (q_q),
      .y_o (dbl_red)
   );

   mod_csub #(.WIDTH(WIDTH)) u_csub_add (
      .x_i (add_raw),
      .q_i (q_q),
      .y_o (add_red)
   );

   // State and datapath registers
   always_ff @(posedge clock_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next state and outputs; outputs decode state_q only
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      q_d         = q_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      result_o    = '0;
      err_o       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               q_d     = q_i;
               acc_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               err_d   = pre_err;
               state_d = pre_err ? ST_DONE : ST_MUL;
            end
         end
         ST_MUL: begin
            acc_d = add_red[WIDTH-1:0];
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DONE: begin
            out_valid_o = 1'b1;
            result_o    = acc_q;
            err_o       = err_q;
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed-vector bench for mod_mul_seq, plus hand sequences
// for backpressure, reset mid-operation and a random sweep.
module tb_mod_mul_seq;

   localparam int W = 12;

   logic          clock_i;
   logic          nreset_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic [W-1:0]  q_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [W-1:0]  result_o;
   logic          err_o;

   int total;
   int bad;
   int cyc;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] res;
      logic         err;
   } vec_t;

   vec_t tv[14];

   mod_mul_seq #(.WIDTH(W)) dut (
      .clock_i     (clock_i),
      .nreset_i    (nreset_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .q_i         (q_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .err_o       (err_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   initial cyc = 0;
   always @(posedge clock_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act,
                      input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_in_ready"}, int'(in_ready_o), 1);
      chk({nm, "_out_valid"}, int'(out_valid_o), 0);
      chk({nm, "_result"}, int'(result_o), 0);
      chk({nm, "_err"}, int'(err_o), 0);
   endtask

   // One full transaction: accept, wait, check, hold, consume
   task automatic do_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] q,
                        input logic [W-1:0] er,
                        input logic ee,
                        input int gap,
                        input string nm,
                        output int acyc);
      int n;
      out_ready_i = (gap == 0);
      @(negedge clock_i);
      a_i = a;
      b_i = b;
      q_i = q;
      in_valid_i = 1'b1;
      n = 0;
      while (!in_ready_o && n < 50) begin
         @(negedge clock_i);
         n++;
      end
      @(posedge clock_i);
      #1;
      acyc = cyc;
      in_valid_i = 1'b0;
      a_i = ~a;
      b_i = ~b;
      q_i = 12'd3;
      chk({nm, "_busy"}, int'(in_ready_o), 0);
      n = 0;
      while (!out_valid_o && n < 50) begin
         @(posedge clock_i);
         #1;
         n++;
      end
      chk({nm, "_latency"}, n, ee ? 0 : W);
      chk({nm, "_result"}, int'(result_o), int'(er));
      chk({nm, "_err"}, int'(err_o), int'(ee));
      for (int k = 0; k < gap; k++) begin
         @(posedge clock_i);
         #1;
         chk({nm, "_hold_valid"}, int'(out_valid_o), 1);
         chk({nm, "_hold_result"}, int'(result_o), int'(er));
         chk({nm, "_hold_busy"}, int'(in_ready_o), 0);
      end
      out_ready_i = 1'b1;
      @(posedge clock_i);
      #1;
      chk({nm, "_consumed"}, int'(out_valid_o), 0);
   endtask

   initial begin
      int ac;
      int prev_ac;
      int qsel;
      int qv;
      int av;
      int bv;
      int g;
      total = 0;
      bad = 0;

      tv[0]  = '{12'd17,   12'd1175, 12'd3329, 12'd1,    1'b0};
      tv[1]  = '{12'd3328, 12'd3328, 12'd3329, 12'd1,    1'b0};
      tv[2]  = '{12'd1234, 12'd2,    12'd3329, 12'd2468, 1'b0};
      tv[3]  = '{12'd0,    12'd2999, 12'd3329, 12'd0,    1'b0};
      tv[4]  = '{12'd16,   12'd16,   12'd17,   12'd1,    1'b0};
      tv[5]  = '{12'd5,    12'd13,   12'd17,   12'd14,   1'b0};
      tv[6]  = '{12'd4092, 12'd2,    12'd4093, 12'd4091, 1'b0};
      tv[7]  = '{12'd1,    12'd1,    12'd2,    12'd1,    1'b0};
      tv[8]  = '{12'd4094, 12'd4094, 12'd4095, 12'd1,    1'b0};
      tv[9]  = '{12'd3329, 12'd5,    12'd3329, 12'd0,    1'b1};
      tv[10] = '{12'd3,    12'd3329, 12'd3329, 12'd0,    1'b1};
      tv[11] = '{12'd0,    12'd0,    12'd1,    12'd0,    1'b1};
      tv[12] = '{12'd6,    12'd6,    12'd7,    12'd1,    1'b0};
      tv[13] = '{12'd0,    12'd0,    12'd0,    12'd0,    1'b1};

      nreset_i = 1'b0;
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      a_i = '0;
      b_i = '0;
      q_i = '0;
      #2;
      chk_rst("reset");
      repeat (3) @(negedge clock_i);
      nreset_i = 1'b1;

      prev_ac = 0;
      for (int i = 0; i < 14; i++) begin
         do_op(tv[i].a, tv[i].b, tv[i].q, tv[i].res,
               tv[i].err, 0, $sformatf("vec%0d", i), ac);
         if (i > 0) begin
            chk($sformatf("vec%0d_interval", i), ac - prev_ac,
                tv[i-1].err ? 2 : W + 2);
         end
         prev_ac = ac;
      end

      do_op(12'd5, 12'd7, 12'd3329, 12'd35, 1'b0, 20,
            "bp", ac);

      @(negedge clock_i);
      a_i = 12'd1000;
      b_i = 12'd3000;
      q_i = 12'd3329;
      in_valid_i = 1'b1;
      @(posedge clock_i);
      #1;
      in_valid_i = 1'b0;
      chk("rst_started", int'(in_ready_o), 0);
      repeat (6) @(posedge clock_i);
      #1;
      nreset_i = 1'b0;
      #1;
      chk_rst("rst_mid");
      @(negedge clock_i);
      nreset_i = 1'b1;
      #1;
      chk_rst("rst_after");
      do_op(12'd100, 12'd200, 12'd3329, 12'd26, 1'b0, 0,
            "post_rst", ac);

      for (int i = 0; i < 200; i++) begin
         qsel = $urandom_range(0, 2);
         qv = (qsel == 0) ? 3329 : (qsel == 1) ? 17 : 4093;
         av = $urandom_range(0, qv - 1);
         bv = $urandom_range(0, qv - 1);
         g = $urandom_range(0, 3);
         repeat ($urandom_range(0, 2)) @(negedge clock_i);
         do_op(W'(av), W'(bv), W'(qv), W'((av * bv) % qv),
               1'b0, g, $sformatf("rnd%0d", i), ac);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
